// File: rtl/mic_sample_arbiter.sv
// ----------------------------------------------------------------------------
// mic_sample_arbiter
//
// Collects samples from three microphone channels into one holding register
// per channel and forwards them, one per cycle at most, through a single
// registered output stage. Channels are served round-robin. A frame is done
// once every enabled channel has delivered at least one sample. A new sample
// that arrives while its channel's holding register is still occupied is
// dropped, and a sticky per-channel overflow flag records the drop.
//
// Ports
//   clk_in         : single clock, all logic on the rising edge
//   rst_in         : synchronous active-high reset
//   ch_en_in       : per-channel enable mask, bit i for mic i
//   valid_in       : per-channel one-cycle strobe, sample_i_in holds new data
//   sample_0/1/2_in: mic samples, WIDTH bits each
//   ready_in       : downstream accepts the output this cycle
//   valid_out      : sample_out / ch_out are valid
//   sample_out     : granted sample
//   ch_out         : source channel of sample_out (0..2)
//   frame_done_out : one-cycle pulse when every enabled channel was delivered
//   overflow_out   : sticky per-channel dropped-sample flags
//   clear_ovf_in   : clears overflow_out (a same-cycle overflow still sets)
// ----------------------------------------------------------------------------
module mic_sample_arbiter #(
   parameter int WIDTH = 18
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [2:0]       ch_en_in,
   input  logic [2:0]       valid_in,
   input  logic [WIDTH-1:0] sample_0_in,
   input  logic [WIDTH-1:0] sample_1_in,
   input  logic [WIDTH-1:0] sample_2_in,
   input  logic             ready_in,
   output logic             valid_out,
   output logic [WIDTH-1:0] sample_out,
   output logic [1:0]       ch_out,
   output logic             frame_done_out,
   output logic [2:0]       overflow_out,
   input  logic             clear_ovf_in
);

   logic [WIDTH-1:0] sample_in [3];
   logic [WIDTH-1:0] hold_q    [3];
   logic [2:0]       full_q;
   logic [1:0]       last_ch_q;
   logic [2:0]       delivered_q;
   logic [2:0]       prev_en_q;

   logic             out_free;
   logic             handshake;
   logic [2:0]       eligible;
   logic             grant_any;
   logic             grant_go;
   logic [1:0]       grant_ch;
   logic [1:0]       cand;
   logic [2:0]       granted;
   logic [2:0]       capture;
   logic [2:0]       ovf_event;
   logic             en_changed;
   logic [2:0]       dlv_next;
   logic             frame_hit;

   // Channel that sits 'step + 1' positions after 'last' in the ring 0,1,2.
   function automatic logic [1:0] rr_index(input logic [1:0] last, input logic [1:0] step);
      logic [2:0] sum;
      sum = {1'b0, last} + {1'b0, step} + 3'd1;
      return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
   endfunction

   assign sample_in[0] = sample_0_in;
   assign sample_in[1] = sample_1_in;
   assign sample_in[2] = sample_2_in;

   assign out_free  = ~valid_out | ready_in;
   assign handshake = valid_out & ready_in;
   assign eligible  = full_q & ch_en_in;

   // Round-robin pick. The scan runs from lowest priority to highest so the
   // last eligible candidate written is the one closest after last_ch_q.
   always_comb begin
      grant_any = 1'b0;
      grant_ch  = 2'd0;
      cand      = 2'd0;
      for (int step = 2; step >= 0; step--) begin
         cand = rr_index(last_ch_q, 2'(step));
         if (eligible[cand]) begin
            grant_any = 1'b1;
            grant_ch  = cand;
         end
      end
   end

   assign grant_go = out_free & grant_any;
   assign granted  = grant_go ? (3'b001 << grant_ch) : 3'b000;

   // A held sample leaving for the output frees its register on the same edge,
   // so a strobe in that cycle is accepted rather than counted as a drop.
   assign capture   = valid_in & ch_en_in & (~full_q | granted);
   assign ovf_event = valid_in & ch_en_in & full_q & ~granted;

   // A handshake only counts towards the frame if its channel is still enabled.
   assign en_changed = (ch_en_in != prev_en_q);
   assign dlv_next   = delivered_q | (handshake ? ((3'b001 << ch_out) & ch_en_in) : 3'b000);
   assign frame_hit  = handshake && (ch_en_in != 3'b000) && ((dlv_next & ch_en_in) == ch_en_in);

   // Holding registers and full flags. Disabling a channel throws away
   // whatever it was holding.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         full_q <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            hold_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!ch_en_in[i]) begin
               full_q[i] <= 1'b0;
            end else if (capture[i]) begin
               full_q[i] <= 1'b1;
               hold_q[i] <= sample_in[i];
            end else if (granted[i]) begin
               full_q[i] <= 1'b0;
            end
         end
      end
   end

   // Output register. It only changes when free, which keeps sample_out and
   // ch_out stable while downstream is stalling. last_ch_q starts at 2 so
   // channel 0 is first in line after reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_out  <= 1'b0;
         sample_out <= '0;
         ch_out     <= 2'd0;
         last_ch_q  <= 2'd2;
      end else if (grant_go) begin
         valid_out  <= 1'b1;
         sample_out <= hold_q[grant_ch];
         ch_out     <= grant_ch;
         last_ch_q  <= grant_ch;
      end else if (out_free) begin
         valid_out  <= 1'b0;
      end
   end

   // Frame tracking: collect delivered channels until the enabled set is
   // covered, then pulse and start over. Any change of the enable mask
   // restarts the frame.
   always_ff @(posedge clk_in) begin
      prev_en_q <= ch_en_in;
      if (rst_in || en_changed) begin
         delivered_q    <= 3'b000;
         frame_done_out <= 1'b0;
      end else if (frame_hit) begin
         delivered_q    <= 3'b000;
         frame_done_out <= 1'b1;
      end else begin
         delivered_q    <= dlv_next;
         frame_done_out <= 1'b0;
      end
   end

   // Sticky overflow flags; a drop in the clearing cycle still leaves its bit set.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         overflow_out <= 3'b000;
      end else begin
         overflow_out <= (clear_ovf_in ? 3'b000 : overflow_out) | ovf_event;
      end
   end

endmodule

// File: doc/mic_sample_arbiter.md
MIC_SAMPLE_ARBITER -- requirements
Module: mic_sample_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 18, the audio sample width in bits.
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ch_en_in, input, 3 bits: per-channel enable mask, bit i for mic i.
REQ-005 SHALL have port valid_in, input, 3 bits: bit i is a one-cycle strobe that sample_i_in holds a new sample.
REQ-006 SHALL have ports sample_0_in, sample_1_in, sample_2_in, input, WIDTH bits each: mic samples.
REQ-007 SHALL have port ready_in, input, 1 bit: downstream accepts the output this cycle.
REQ-008 SHALL have port valid_out, output, 1 bit: sample_out and ch_out are valid.
REQ-009 SHALL have port sample_out, output, WIDTH bits: the granted sample.
REQ-010 SHALL have port ch_out, output, 2 bits: source channel of sample_out (0..2).
REQ-011 SHALL have port frame_done_out, output, 1 bit: one-cycle pulse when a frame completes.
REQ-012 SHALL have port overflow_out, output, 3 bits: sticky per-channel dropped-sample flags.
REQ-013 SHALL have port clear_ovf_in, input, 1 bit: clears overflow_out.

Function
REQ-014 SHALL keep one holding register and one full flag per channel.
REQ-015 SHALL capture sample_i_in into holding register i when valid_in[i] and ch_en_in[i] are high and the register is either empty or being granted in the same cycle; full[i] is 1 on the next cycle.
REQ-016 SHALL drop the new sample and set overflow_out[i] when valid_in[i] and ch_en_in[i] are high, full[i] is 1 and channel i is not granted that cycle; the held sample is kept.
REQ-017 SHALL ignore valid_in[i] while ch_en_in[i] is 0, and SHALL clear full[i] on the next edge after ch_en_in[i] goes 0, discarding the held sample.
REQ-018 SHALL define the output register as free when valid_out is 0 or when valid_out and ready_in are both 1.
REQ-019 SHALL grant, when the output register is free, one full enabled channel, chosen by round-robin starting at the channel after the last granted channel.
REQ-020 SHALL load the granted sample and channel into the output register, clear that full flag, and assert valid_out on the next cycle.
REQ-021 SHALL deassert valid_out on the next cycle when the output register is free and no channel is full.
REQ-022 SHALL hold sample_out and ch_out stable while valid_out is 1 and ready_in is 0.
REQ-023 SHALL have a minimum latency of 2 cycles from a valid_in strobe to valid_out (capture edge, then grant edge). A sustained ready_in gives one sample per cycle.
REQ-024 SHALL count a handshake (valid_out and ready_in) as delivering channel ch_out: the delivered mask bit is set if that channel is enabled.
REQ-025 SHALL pulse frame_done_out on the cycle after the handshake that makes the delivered mask cover ch_en_in, and SHALL clear the mask on that same edge.
REQ-026 SHALL never pulse frame_done_out while ch_en_in is 0; any change of ch_en_in SHALL clear the delivered mask.
REQ-027 SHALL deliver a sample already in the output register even if its channel is then disabled; that sample SHALL NOT set a delivered bit.
REQ-028 SHALL clear overflow_out when clear_ovf_in is 1; if an overflow event occurs in the same cycle for channel i, overflow_out[i] SHALL be set (set wins).

Reset
REQ-029 SHALL, while rst_in is high, drive valid_out=0, sample_out=0, ch_out=0, frame_done_out=0, overflow_out=0, and clear all full flags and the delivered mask.
REQ-030 SHALL set the round-robin pointer so channel 0 has first priority after reset.
REQ-031 SHALL discard held and in-flight samples on reset mid-operation; no valid_out in the cycle after rst_in deasserts.

Verification
REQ-032 SHALL be tested: ch_en=3'b111, ready=1, valid_in=3'b111 at cycle 0 with samples 0x00001/0x00002/0x00003 -> ch_out 0,1,2 at cycles 2,3,4; frame_done_out pulse at cycle 5.
REQ-033 SHALL be tested: ready=0, two strobes on ch1 with 0x00AAA then 0x00BBB -> overflow_out=3'b010, and 0x00AAA is delivered when ready rises.
REQ-034 SHALL be tested: valid_out=1 and ready low for 5 cycles with ch0/ch2 pending -> sample_out and ch_out stable; then ready high -> ch0 then ch2 are output.
REQ-035 SHALL be tested: ch_en=3'b101 with full strobes -> ch1 never granted; frame_done_out after ch0 and ch2 are delivered.
REQ-036 SHALL be tested: clear_ovf_in in the same cycle as a ch0 overflow -> overflow_out[0]=1, other bits 0.
REQ-037 SHALL be tested: rst_in for 1 cycle with all channels full and valid_out=1 -> all outputs 0 the next cycle, and the first grant after new strobes is ch0.
